sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address bits of the internal array (2^ADDR_W x 16-bit words).
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Mem_OE  input  1  read strobe from control unit, active-high.
REQ-005 Mem_WE  input  1  write strobe from control unit, active-high.
REQ-006 ADDR  input  16  word address (MAR).
REQ-007 Data_from_CPU  input  16  write data (MDR).
REQ-008 Data_to_CPU  output  16  registered read data.
REQ-009 Mem_Ready  output  1  read data valid or write committed.
REQ-010 Mem_Err  output  1  sticky protocol-error flag.
REQ-011 Err_Clr  input  1  synchronous clear of Mem_Err.
REQ-012 SW  input  16  switch inputs (I/O read port).
REQ-013 Hex_Out  output  16  registered display value (I/O write port).

Function
REQ-014 States: IDLE, READ, WR_ARM, WR_DONE; all transitions on rising Clk.
REQ-015 IDLE, OE=1, WE=0: latch ADDR; Data_to_CPU <= word at that address at end of same cycle; go READ (read latency 1 cycle, data valid in 2nd OE cycle).
REQ-016 READ: Data_to_CPU held stable; Mem_Ready=1; stay while OE=1; OE=0 -> IDLE; WE ignored.
REQ-017 IDLE, WE=1, OE=0: latch ADDR and Data_from_CPU; go WR_ARM; no write yet.
REQ-018 WR_ARM, WE=1: commit latched data to latched address at end of cycle; go WR_DONE.
REQ-019 WR_ARM, WE=0: write aborted (no array/Hex_Out change); Mem_Err <= 1; go IDLE.
REQ-020 WR_DONE: Mem_Ready=1; further WE cycles cause no rewrite; WE=0 -> IDLE.
REQ-021 IDLE, OE=1 and WE=1 simultaneously: no access, Mem_Err <= 1, remain IDLE.
REQ-022 OE asserted in WR_ARM/WR_DONE is ignored; no error.
REQ-023 Addressing: array index = ADDR[ADDR_W-1:0]; upper bits ignored (aliasing), except I/O address per REQ-028.
REQ-024 Mem_Ready=0 in IDLE and WR_ARM.
REQ-025 Err_Clr=1 clears Mem_Err; if an error event coincides, set wins.
REQ-026 Array contents not initialised by reset; read of unwritten word returns undefined.

Reset
REQ-027 Reset=0 asynchronously: state IDLE, Data_to_CPU=0x0000, Mem_Ready=0, Mem_Err=0, Hex_Out=0x0000; in-flight write discarded; array contents unchanged.

Configuration
REQ-028 Macro SRAM_RESPONDER_IO_EN defined: ADDR=0xFFFF is the I/O port -- reads return SW sampled in the latch cycle, writes commit to Hex_Out not the array. Undefined: 0xFFFF aliases into the array like any address; Hex_Out constant 0x0000; SW unused.

Verification
REQ-029 WE=1 for 2 cycles, ADDR=0x0012, data=0xBEEF, then OE=1 for 2 cycles same ADDR -> Data_to_CPU=0xBEEF in 2nd OE cycle, Mem_Ready=1 in 2nd cycle of each access.
REQ-030 WE=1 for 1 cycle only, ADDR=0x0012, data=0x1234 -> Mem_Err=1; subsequent read of 0x0012 returns 0xBEEF; Err_Clr pulse -> Mem_Err=0.
REQ-031 OE=1 and WE=1 together in IDLE -> Mem_Err=1, state stays IDLE, Mem_Ready=0, no array change.
REQ-032 ADDR_W=10: write 0x5A5A to 0x0405, read 0x0005 -> 0x5A5A (alias).
REQ-033 With SRAM_RESPONDER_IO_EN: SW=0x00C3, read 0xFFFF -> 0x00C3; write 0x0042 to 0xFFFF -> Hex_Out=0x0042; without macro, Hex_Out stays 0x0000.
REQ-034 Reset=0 asserted during WR_ARM -> outputs per REQ-027 immediately, target word unchanged after release.

Source files
------------

// File: rtl/sram_responder.sv
// Handshaked 16-bit SRAM responder with two-cycle write arming, sticky protocol error
// and, when SRAM_RESPONDER_IO_EN is defined, a memory-mapped switch/hex I/O port at 0xFFFF.
module sram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic        Mem_Err,
  input  logic        Err_Clr,
  input  logic [15:0] SW,
  output logic [15:0] Hex_Out
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WR_ARM, S_WR_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_dout;
  logic [15:0] r_hex;
  logic        r_ready;
  logic        r_err;
  logic [15:0] r_mem [2**ADDR_W];

  logic [ADDR_W-1:0] w_ridx;
  logic [ADDR_W-1:0] w_widx;
  logic              w_io_rd;
  logic              w_io_wr;
  logic              w_commit;
  logic              w_err_set;
  logic              w_unused;

  assign w_ridx = ADDR[ADDR_W-1:0];
  assign w_widx = r_addr[ADDR_W-1:0];

`ifdef SRAM_RESPONDER_IO_EN
  assign w_io_rd = (ADDR == 16'hFFFF);
  assign w_io_wr = (r_addr == 16'hFFFF);
`else
  assign w_io_rd = 1'b0;
  assign w_io_wr = 1'b0;
`endif

  // Bits that only matter when the I/O port is built in.
  assign w_unused = ^{SW, ADDR, r_addr};

  assign w_commit  = (r_state == S_WR_ARM) && Mem_WE;
  assign w_err_set = ((r_state == S_IDLE) && Mem_OE && Mem_WE) ||
                     ((r_state == S_WR_ARM) && !Mem_WE);

  // Array has no reset; reset only forces the FSM to IDLE so an armed write never commits.
  always_ff @(posedge Clk) begin
    if (Reset && w_commit && !w_io_wr)
      r_mem[w_widx] <= r_wdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_dout  <= '0;
      r_hex   <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err_set | (r_err & ~Err_Clr);
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          if (Mem_OE && !Mem_WE) begin
            r_addr  <= ADDR;
            r_dout  <= w_io_rd ? SW : r_mem[w_ridx];
            r_ready <= 1'b1;
            r_state <= S_READ;
          end else if (Mem_WE && !Mem_OE) begin
            r_addr  <= ADDR;
            r_wdata <= Data_from_CPU;
            r_state <= S_WR_ARM;
          end
        end
        S_READ: begin
          if (!Mem_OE) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WR_ARM: begin
          if (Mem_WE) begin
            if (w_io_wr)
              r_hex <= r_wdata;
            r_ready <= 1'b1;
            r_state <= S_WR_DONE;
          end else begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WR_DONE: begin
          if (!Mem_WE) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Data_to_CPU = r_dout;
  assign Mem_Ready   = r_ready;
  assign Mem_Err     = r_err;
  assign Hex_Out     = r_hex;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: handshake timing, aborted writes, collisions,
// aliasing, I/O port (SRAM_RESPONDER_IO_EN) and reset during an armed write.
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;
  logic        Mem_Err;
  logic        Err_Clr = 1'b0;
  logic [15:0] SW = '0;
  logic [15:0] Hex_Out;

  int checks = 0;
  int failures = 0;

  sram_responder #(.ADDR_W(10)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
    .Mem_Err(Mem_Err), .Err_Clr(Err_Clr), .SW(SW), .Hex_Out(Hex_Out)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; Data_from_CPU = d; Mem_WE = 1'b1;
    cyc(); cyc();
    Mem_WE = 1'b0;
    cyc();
  endtask

  task automatic do_read(input logic [15:0] a, output logic [15:0] d);
    ADDR = a; Mem_OE = 1'b1;
    cyc();
    d = Data_to_CPU;
    Mem_OE = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", Data_to_CPU); end
    checks++; if (Mem_Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", Mem_Ready); end
    checks++; if (Mem_Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", Mem_Err); end
    checks++; if (Hex_Out !== 16'h0000) begin failures++; $display("FAIL reset_hex got=%h exp=0000", Hex_Out); end
    @(negedge Clk);
    Reset = 1'b1;
    cyc();
  endtask

  task automatic test_write_read();
    ADDR = 16'h0012; Data_from_CPU = 16'hBEEF; Mem_WE = 1'b1;
    cyc();
    checks++; if (Mem_Ready !== 1'b0) begin failures++; $display("FAIL wr_arm_ready got=%b exp=0", Mem_Ready); end
    Mem_OE = 1'b1;  // OE while armed is ignored
    cyc();
    checks++; if (Mem_Ready !== 1'b1) begin failures++; $display("FAIL wr_done_ready got=%b exp=1", Mem_Ready); end
    checks++; if (Mem_Err !== 1'b0) begin failures++; $display("FAIL wr_oe_ignored_err got=%b exp=0", Mem_Err); end
    Mem_OE = 1'b0; Data_from_CPU = 16'h7777;  // extra WE cycle in WR_DONE must not rewrite
    cyc();
    checks++; if (Mem_Ready !== 1'b1) begin failures++; $display("FAIL wr_done_hold got=%b exp=1", Mem_Ready); end
    Mem_WE = 1'b0;
    cyc();
    checks++; if (Mem_Ready !== 1'b0) begin failures++; $display("FAIL wr_idle_ready got=%b exp=0", Mem_Ready); end
    ADDR = 16'h0012; Mem_OE = 1'b1;
    cyc();
    checks++; if (Data_to_CPU !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=beef", Data_to_CPU); end
    checks++; if (Mem_Ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%b exp=1", Mem_Ready); end
    Mem_WE = 1'b1; ADDR = 16'h0099;  // WE and new address ignored during READ
    cyc();
    checks++; if (Data_to_CPU !== 16'hBEEF || Mem_Ready !== 1'b1 || Mem_Err !== 1'b0) begin failures++;
      $display("FAIL rd_hold got=%h/%b/%b exp=beef/1/0", Data_to_CPU, Mem_Ready, Mem_Err); end
    Mem_WE = 1'b0; Mem_OE = 1'b0;
    cyc();
    checks++; if (Mem_Ready !== 1'b0) begin failures++; $display("FAIL rd_release_ready got=%b exp=0", Mem_Ready); end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    ADDR = 16'h0012; Data_from_CPU = 16'h1234; Mem_WE = 1'b1;
    cyc();
    Mem_WE = 1'b0;
    cyc();
    checks++; if (Mem_Err !== 1'b1) begin failures++; $display("FAIL abort_err got=%b exp=1", Mem_Err); end
    do_read(16'h0012, d);
    checks++; if (d !== 16'hBEEF) begin failures++; $display("FAIL abort_nowrite got=%h exp=beef", d); end
    Err_Clr = 1'b1;
    cyc();
    Err_Clr = 1'b0;
    checks++; if (Mem_Err !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", Mem_Err); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    ADDR = 16'h0012; Data_from_CPU = 16'hDEAD; Mem_OE = 1'b1; Mem_WE = 1'b1;
    cyc();
    checks++; if (Mem_Err !== 1'b1 || Mem_Ready !== 1'b0) begin failures++;
      $display("FAIL collide got=err%b/rdy%b exp=err1/rdy0", Mem_Err, Mem_Ready); end
    Err_Clr = 1'b1;  // set wins over clear
    cyc();
    checks++; if (Mem_Err !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=1", Mem_Err); end
    Err_Clr = 1'b0; Mem_WE = 1'b0;  // still IDLE, so OE alone reads right away
    cyc();
    checks++; if (Data_to_CPU !== 16'hBEEF || Mem_Ready !== 1'b1) begin failures++;
      $display("FAIL collide_noaccess got=%h/%b exp=beef/1", Data_to_CPU, Mem_Ready); end
    Mem_OE = 1'b0; Err_Clr = 1'b1;
    cyc();
    Err_Clr = 1'b0;
    do_read(16'h0012, d);
    checks++; if (d !== 16'hBEEF || Mem_Err !== 1'b0) begin failures++;
      $display("FAIL collide_after got=%h/%b exp=beef/0", d, Mem_Err); end
  endtask

  task automatic test_alias();
    logic [15:0] d;
    do_write(16'h0405, 16'h5A5A);
    do_read(16'h0005, d);
    checks++; if (d !== 16'h5A5A) begin failures++; $display("FAIL alias got=%h exp=5a5a", d); end
    do_write(16'h0006, 16'hC0DE);
    do_read(16'hFC06, d);
    checks++; if (d !== 16'hC0DE) begin failures++; $display("FAIL alias_hi got=%h exp=c0de", d); end
  endtask

  task automatic test_io();
    logic [15:0] d;
    SW = 16'h00C3;
    do_write(16'h03FF, 16'h1111);
    do_write(16'hFFFF, 16'h0042);
`ifdef SRAM_RESPONDER_IO_EN
    checks++; if (Hex_Out !== 16'h0042) begin failures++; $display("FAIL io_hex got=%h exp=0042", Hex_Out); end
    do_read(16'hFFFF, d);
    checks++; if (d !== 16'h00C3) begin failures++; $display("FAIL io_sw got=%h exp=00c3", d); end
    do_read(16'h03FF, d);
    checks++; if (d !== 16'h1111) begin failures++; $display("FAIL io_noarray got=%h exp=1111", d); end
`else
    checks++; if (Hex_Out !== 16'h0000) begin failures++; $display("FAIL noio_hex got=%h exp=0000", Hex_Out); end
    do_read(16'hFFFF, d);
    checks++; if (d !== 16'h0042) begin failures++; $display("FAIL noio_ffff got=%h exp=0042", d); end
    do_read(16'h03FF, d);
    checks++; if (d !== 16'h0042) begin failures++; $display("FAIL noio_alias got=%h exp=0042", d); end
`endif
  endtask

  task automatic test_reset_in_wr_arm();
    logic [15:0] d;
    do_write(16'h0030, 16'h1111);
    do_read(16'h0030, d);  // leaves Data_to_CPU nonzero
    ADDR = 16'h0012; Mem_OE = 1'b1; Mem_WE = 1'b1;
    cyc();  // collision sets the error flag
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    cyc();
    ADDR = 16'h0030; Data_from_CPU = 16'h2222; Mem_WE = 1'b1;
    cyc();
    checks++; if (Mem_Err !== 1'b1 || Data_to_CPU !== 16'h1111) begin failures++;
      $display("FAIL pre_reset got=%b/%h exp=1/1111", Mem_Err, Data_to_CPU); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (Data_to_CPU !== 16'h0000 || Mem_Ready !== 1'b0 || Mem_Err !== 1'b0 || Hex_Out !== 16'h0000) begin
      failures++; $display("FAIL async_reset got=%h/%b/%b/%h exp=0000/0/0/0000", Data_to_CPU, Mem_Ready, Mem_Err, Hex_Out); end
    cyc(); cyc();
    Mem_WE = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    cyc();
    do_read(16'h0030, d);
    checks++; if (d !== 16'h1111) begin failures++; $display("FAIL reset_discard got=%h exp=1111", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_collision();
    test_alias();
    test_io();
    test_reset_in_wr_arm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
